// File: rtl/wash_pkg.sv
// Shared wash-station definitions: phase encodings, program codes, prices and durations.
package wash_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StFill,
        StWash,
        StRinse,
        StSpin,
        StDone,
        StErr
    } state_t;

    localparam logic [1:0] ModeQuick   = 2'd0;
    localparam logic [1:0] ModeNormal  = 2'd1;
    localparam logic [1:0] ModeHeavy   = 2'd2;
    localparam logic [1:0] ModeInvalid = 2'd3;

    localparam logic [7:0] FillSecs  = 8'd5;
    localparam logic [7:0] RinseSecs = 8'd10;
    localparam logic [7:0] SpinSecs  = 8'd8;

    function automatic logic [7:0] price_of(input logic [1:0] m);
        case (m)
            ModeQuick:  price_of = 8'd3;
            ModeNormal: price_of = 8'd5;
            ModeHeavy:  price_of = 8'd8;
            default:    price_of = 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] wash_secs(input logic [1:0] m);
        case (m)
            ModeQuick:  wash_secs = 8'd10;
            ModeNormal: wash_secs = 8'd20;
            ModeHeavy:  wash_secs = 8'd30;
            default:    wash_secs = 8'd0;
        endcase
    endfunction

    function automatic logic is_timed(input state_t s);
        is_timed = (s == StFill) || (s == StWash) || (s == StRinse) || (s == StSpin);
    endfunction

    function automatic state_t next_phase(input state_t s);
        case (s)
            StFill:  next_phase = StWash;
            StWash:  next_phase = StRinse;
            StRinse: next_phase = StSpin;
            default: next_phase = StDone;
        endcase
    endfunction

    // Seconds loaded on entry to a phase; untimed phases show 0.
    function automatic logic [7:0] phase_secs(input state_t s, input logic [1:0] m);
        case (s)
            StFill:  phase_secs = FillSecs;
            StWash:  phase_secs = wash_secs(m);
            StRinse: phase_secs = RinseSecs;
            StSpin:  phase_secs = SpinSecs;
            default: phase_secs = 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] lamp(input state_t s);
        case (s)
            StIdle:  lamp = 8'b0000_0001;
            StFill:  lamp = 8'b0000_0010;
            StWash:  lamp = 8'b0000_0100;
            StRinse: lamp = 8'b0000_1000;
            StSpin:  lamp = 8'b0001_0000;
            StDone:  lamp = 8'b0010_0000;
            StErr:   lamp = 8'b0100_0000;
            default: lamp = 8'b1000_0000;
        endcase
    endfunction

endpackage

// File: rtl/sec_tick.sv
// One-second strobe generator: pulses tick once every TICK_DIV cycles while clr is low.
module sec_tick #(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Count up and wrap; clr holds the count at zero so a full period follows its release.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wash_seq.sv
// Car-wash cycle sequencer: checks balance, charges once, then runs timed phases to DONE.
module wash_seq
    import wash_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic [1:0]  mode,
    input  logic [11:0] bal,
    output logic        debit,
    output logic [7:0]  price,
    output logic [7:0]  remain,
    output logic [7:0]  st_light,
    output logic        done
);

    state_t     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic       start_q;
    logic [7:0] remain_q, remain_d;
    logic       debit_q, debit_d;
    logic [7:0] price_q, price_d;
    logic [7:0] light_q, light_d;
    logic       done_q, done_d;
    logic       tick;
    logic       start_rise;
    logic       short_funds;

    assign start_rise  = start & ~start_q;
    assign short_funds = $signed(bal) < $signed({4'b0000, price_of(mode_q)});

    // Tick counter only runs in a timed phase with pause low.
    sec_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_sec_tick (
        .clk (clk),
        .rst (rst),
        .clr (pause | ~is_timed(state_q)),
        .tick(tick)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        remain_d = remain_q;
        debit_d  = 1'b0;
        price_d  = 8'd0;
        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    state_d = StCheck;
                    mode_d  = mode;
                end
            end
            StCheck: begin
                if (mode_q == ModeInvalid || short_funds) begin
                    state_d = StErr;
                end else begin
                    state_d  = StFill;
                    remain_d = FillSecs;
                    debit_d  = 1'b1;
                    price_d  = price_of(mode_q);
                end
            end
            StFill, StWash, StRinse, StSpin: begin
                if (tick && !pause) begin
                    if (remain_q == 8'd1) begin
                        // Enter next phase with its duration already loaded.
                        state_d  = next_phase(state_q);
                        remain_d = phase_secs(next_phase(state_q), mode_q);
                    end else begin
                        remain_d = remain_q - 8'd1;
                    end
                end
            end
            StDone, StErr: begin
                if (start_rise) begin
                    state_d = StIdle;
                end
            end
        endcase
        light_d = lamp(state_d);
        done_d  = (state_d == StDone);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            mode_q   <= 2'd0;
            start_q  <= 1'b0;
            remain_q <= 8'd0;
            debit_q  <= 1'b0;
            price_q  <= 8'd0;
            light_q  <= 8'b0000_0001;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            start_q  <= start;
            remain_q <= remain_d;
            debit_q  <= debit_d;
            price_q  <= price_d;
            light_q  <= light_d;
            done_q   <= done_d;
        end
    end

    assign debit    = debit_q;
    assign price    = price_q;
    assign remain   = remain_q;
    assign st_light = light_q;
    assign done     = done_q;

endmodule

// File: tb/tb_wash_seq.sv
// Scoreboard bench for wash_seq with a 4-cycle second.
module tb_wash_seq;

    localparam int unsigned TickDiv = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] bal = 12'd0;
    logic        debit;
    logic [7:0]  price;
    logic [7:0]  remain;
    logic [7:0]  st_light;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] light;
        logic [7:0] remain;
        int         dwell;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] price_exp_q[$];

    wash_seq #(
        .TICK_DIV(TickDiv)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pause   (pause),
        .mode    (mode),
        .bal     (bal),
        .debit   (debit),
        .price   (price),
        .remain  (remain),
        .st_light(st_light),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic int exp_price(input logic [1:0] m);
        case (m)
            2'd0:    return 3;
            2'd1:    return 5;
            2'd2:    return 8;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_wash(input logic [1:0] m);
        case (m)
            2'd0:    return 10;
            2'd1:    return 20;
            default: return 30;
        endcase
    endfunction

    // Push the expected phase sequence and charge for one started cycle.
    task automatic push_cycle(input logic [1:0] m, input logic [11:0] b);
        bit ok;
        int w;
        ev_t e;
        ok = (m != 2'd3) && ($signed(b) >= exp_price(m));
        e.light = 8'h80; e.remain = 8'd0; e.dwell = 1; ev_q.push_back(e);
        if (ok) begin
            w = exp_wash(m);
            price_exp_q.push_back(8'(exp_price(m)));
            e.light = 8'h02; e.remain = 8'd5;   e.dwell = 5 * TickDiv;  ev_q.push_back(e);
            e.light = 8'h04; e.remain = 8'(w);  e.dwell = w * TickDiv;  ev_q.push_back(e);
            e.light = 8'h08; e.remain = 8'd10;  e.dwell = 10 * TickDiv; ev_q.push_back(e);
            e.light = 8'h10; e.remain = 8'd8;   e.dwell = 8 * TickDiv;  ev_q.push_back(e);
            e.light = 8'h20; e.remain = 8'd0;   e.dwell = -1;           ev_q.push_back(e);
        end else begin
            e.light = 8'h40; e.remain = 8'd0; e.dwell = -1; ev_q.push_back(e);
        end
    endtask

    // Pop and compare on every lamp change and debit pulse until the queue drains.
    task automatic monitor(input int budget, input int start_len);
        logic [7:0] prev_light;
        logic [7:0] p;
        int cyc, prev_dwell, total;
        bit stray;
        ev_t e;
        prev_light = st_light;
        cyc = 0; prev_dwell = -1; total = 0; stray = 0;
        while (ev_q.size() > 0 && total < budget) begin
            @(negedge clk);
            total++;
            cyc++;
            if (total == start_len) start = 1'b0;
            // Inputs changed after CHECK must have no effect.
            if (total == 3) begin
                mode = 2'd3;
                bal  = 12'h800;
            end
            if (debit) begin
                n_checks++;
                if (price_exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_debit: price=%0d light=%b", price, st_light);
                end else begin
                    p = price_exp_q.pop_front();
                    if (price !== p || st_light !== 8'h02) begin
                        n_fail++;
                        $display("FAIL debit_price: got price=%0d light=%b, want price=%0d light=00000010",
                                 price, st_light, p);
                    end
                end
            end else if (price !== 8'd0) begin
                stray = 1;
            end
            if (st_light !== prev_light) begin
                e = ev_q.pop_front();
                n_checks++;
                if (st_light !== e.light || remain !== e.remain || done !== (e.light == 8'h20)) begin
                    n_fail++;
                    $display("FAIL phase_entry: got light=%b remain=%0d done=%b, want light=%b remain=%0d",
                             st_light, remain, done, e.light, e.remain);
                end
                if (prev_dwell >= 0) begin
                    n_checks++;
                    if (cyc != prev_dwell) begin
                        n_fail++;
                        $display("FAIL phase_dwell: got %0d cycles, want %0d (now light=%b)",
                                 cyc, prev_dwell, st_light);
                    end
                end
                prev_dwell = e.dwell;
                cyc = 0;
                prev_light = st_light;
            end
        end
        n_checks++;
        if (ev_q.size() != 0) begin
            n_fail++;
            $display("FAIL sequence_timeout: %0d phases still pending, want 0", ev_q.size());
        end
        n_checks++;
        if (price_exp_q.size() != 0 || stray) begin
            n_fail++;
            $display("FAIL charge_count: %0d charges missing, stray price=%0d, want 0/0",
                     price_exp_q.size(), stray);
        end
        ev_q.delete();
        price_exp_q.delete();
        start = 1'b0;
    endtask

    // Start edge from DONE/ERR returns to IDLE and must not begin a new cycle.
    task automatic return_to_idle(input int hold);
        bit bad;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        n_checks++;
        if (st_light !== 8'h01 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_idle: got light=%b done=%b, want 00000001/0", st_light, done);
        end
        bad = 0;
        repeat (hold + 4) begin
            @(negedge clk);
            if (st_light !== 8'h01 || debit !== 1'b0) bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL idle_no_restart: got light=%b debit=%b, want 00000001/0", st_light, debit);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (st_light !== 8'h01 || remain !== 8'd0 || debit !== 1'b0 || price !== 8'd0 ||
            done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got light=%b remain=%0d debit=%b price=%0d done=%b, want 00000001/0/0/0/0",
                     st_light, remain, debit, price, done);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_normal_cycle();
        mode = 2'd1; bal = 12'd20;
        push_cycle(2'd1, 12'd20);
        start = 1'b1;
        monitor(400, 1);
        return_to_idle(0);
    endtask

    task automatic test_errors();
        mode = 2'd2; bal = 12'd7;
        push_cycle(2'd2, 12'd7);
        start = 1'b1;
        monitor(50, 1);
        return_to_idle(0);
        mode = 2'd0; bal = 12'hFFF;
        push_cycle(2'd0, 12'hFFF);
        start = 1'b1;
        monitor(50, 1);
        return_to_idle(0);
        mode = 2'd3; bal = 12'd100;
        push_cycle(2'd3, 12'd100);
        start = 1'b1;
        monitor(50, 1);
        return_to_idle(0);
    endtask

    task automatic test_start_held();
        mode = 2'd0; bal = 12'd3;
        push_cycle(2'd0, 12'd3);
        start = 1'b1;
        monitor(400, 0);
        start = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (st_light !== 8'h20 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL held_start_done: got light=%b done=%b, want 00100000/1", st_light, done);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (st_light !== 8'h20) begin
            n_fail++;
            $display("FAIL start_fall_done: got light=%b, want 00100000", st_light);
        end
        return_to_idle(6);
    endtask

    task automatic test_pause();
        int guard;
        bit moved;
        mode = 2'd2; bal = 12'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(st_light == 8'h04 && remain == 8'd12) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (guard >= 1000) begin
            n_fail++;
            $display("FAIL pause_reach: got light=%b remain=%0d, want 00000100/12", st_light, remain);
        end
        pause = 1'b1;
        moved = 0;
        repeat (40) begin
            @(negedge clk);
            if (remain !== 8'd12 || st_light !== 8'h04) moved = 1;
        end
        n_checks++;
        if (moved) begin
            n_fail++;
            $display("FAIL pause_hold: got remain=%0d light=%b, want 12/00000100", remain, st_light);
        end
        pause = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (remain !== 8'd12) begin
            n_fail++;
            $display("FAIL pause_release_early: got remain=%0d, want 12", remain);
        end
        @(negedge clk);
        n_checks++;
        if (remain !== 8'd11) begin
            n_fail++;
            $display("FAIL pause_release_step: got remain=%0d, want 11", remain);
        end
    endtask

    task automatic test_reset_mid_rinse();
        int guard;
        guard = 0;
        while (st_light != 8'h08 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        repeat (6) @(negedge clk);
        n_checks++;
        if (st_light !== 8'h08 || remain == 8'd0) begin
            n_fail++;
            $display("FAIL rinse_reach: got light=%b remain=%0d, want 00001000/nonzero", st_light, remain);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (st_light !== 8'h01 || remain !== 8'd0 || debit !== 1'b0 || price !== 8'd0 ||
            done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_rinse: got light=%b remain=%0d debit=%b price=%0d done=%b, want 00000001/0/0/0/0",
                     st_light, remain, debit, price, done);
        end
        rst = 1'b1;
        @(negedge clk);
        mode = 2'd1; bal = 12'd20;
        push_cycle(2'd1, 12'd20);
        start = 1'b1;
        monitor(400, 1);
        return_to_idle(0);
    endtask

    initial begin
        test_reset();
        test_normal_cycle();
        test_errors();
        test_start_held();
        test_pause();
        test_reset_mid_rinse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wash_seq.md
WASH_SEQ -- requirements
Module: wash_seq

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, clk cycles per 1 s tick (sim uses 4).
REQ-002 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-003 SHALL have port rst  input  1  reset; one clock domain, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  level; rising edge (1 after 0) starts a cycle from IDLE.
REQ-005 SHALL have port pause  input  1  level; while 1 in a timed phase, the countdown freezes.
REQ-006 SHALL have port mode  input  2  program: 0 quick, 1 normal, 2 heavy, 3 invalid.
REQ-007 SHALL have port bal  input  12 signed  customer balance.
REQ-008 SHALL have port debit  output  1  one-cycle pulse requesting the charge.
REQ-009 SHALL have port price  output  8  charge amount, valid while debit=1, else 0.
REQ-010 SHALL have port remain  output  8  seconds left in the current phase, else 0.
REQ-011 SHALL have port st_light  output  8  one-hot phase lamp.
REQ-012 SHALL have port done  output  1  high in DONE.

Function
REQ-013 SHALL implement the states IDLE, CHECK, FILL, WASH, RINSE, SPIN, DONE and ERR.
REQ-014 SHALL, in IDLE, go to CHECK on a start rising edge, latching mode into mode_q.
REQ-015 SHALL, in CHECK (one cycle), go to ERR if mode_q==3 or bal < price(mode_q), else go to FILL and assert debit with price=price(mode_q) for that cycle only.
REQ-016 SHALL use prices 3/5/8 for modes 0/1/2; the bal comparison is signed, so negative bal always fails.
REQ-017 SHALL use durations FILL 5 s, WASH 10/20/30 s (by mode_q), RINSE 10 s and SPIN 8 s.
REQ-018 SHALL, on entry to each timed phase, load remain with its duration in the same cycle as the state change.
REQ-019 SHALL decrement remain by 1 on each tick while pause=0; on a tick with remain==1, remain becomes 0 and the next phase is entered with its duration loaded (no zero-second dwell).
REQ-020 SHALL clear the tick counter and hold it cleared while pause=1, so that after pause falls a full TICK_DIV elapses before the next decrement.
REQ-021 SHALL advance FILL->WASH->RINSE->SPIN->DONE.
REQ-022 SHALL make DONE and ERR return to IDLE only on a start rising edge; that edge SHALL NOT also begin a new cycle.
REQ-023 SHALL drive st_light one-hot as bit0 IDLE, 1 FILL, 2 WASH, 3 RINSE, 4 SPIN, 5 DONE, 6 ERR, 7 CHECK.
REQ-024 SHALL give pause priority over a tick in the same cycle; pause SHALL be ignored outside FILL..SPIN.
REQ-025 SHALL ignore changes to mode and bal after CHECK.
REQ-026 SHALL ignore start held high: only 0->1 transitions act, using a registered previous value.
REQ-027 SHALL register all outputs and assert debit at most once per cycle started.

Reset
REQ-028 SHALL, on rst=0 at any time (including mid-phase), immediately return to IDLE with remain=0, debit=0, price=0, done=0, st_light=8'b00000001, tick counter 0, mode_q 0 and start history 0.
REQ-029 SHALL issue no refund or debit as a result of reset.

Structure
REQ-030 SHALL take the state encodings, the mode codes, the price table and the duration table from the shared wash_pkg include, which is also used by the billing/display blocks.
REQ-031 SHALL instantiate one sub-module, sec_tick (parameter TICK_DIV; ports clk, rst, clr, tick), as the 1 s strobe generator.

Verification (TICK_DIV=4)
REQ-032 SHALL cover: mode=1, bal=20, start pulse -> one debit pulse with price=5, then FILL 5/WASH 20/RINSE 10/SPIN 8 ticks, then done=1 and st_light=8'b00100000.
REQ-033 SHALL cover: mode=2, bal=7 -> ERR with no debit and st_light=8'b01000000; a start edge returns to IDLE.
REQ-034 SHALL cover: mode=0, bal=-1 -> ERR; mode=3, bal=100 -> ERR.
REQ-035 SHALL cover: pause held 40 cycles in WASH with remain=12 -> remain stays 12; after release, the first decrement occurs exactly 4 cycles later.
REQ-036 SHALL cover: rst=0 mid-RINSE -> next cycle shows IDLE outputs, with no debit on the subsequent restart until CHECK.
REQ-037 SHALL cover: start held high through DONE -> no return to IDLE until start falls and rises again.
